// File: rtl/tvp_clk_pkg.sv
`timescale 1ns / 10ps
// State encoding and default tuning for the TVP5147M1 crystal-clock lock sequencer.
package tvp_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        MEASURE   = 2'd1,
        HOLD_RST  = 2'd2,
        RUN       = 2'd3
    } lock_state_t;

    // 50 MHz refclk: 1 ms gate gives ~14318 edges of the 14.318181 MHz clock (+/-0.2% window).
    localparam int DEF_GATE_CYCLES     = 50000;
    localparam int DEF_CNT_W           = 16;
    localparam int DEF_CNT_MIN         = 14290;
    localparam int DEF_CNT_MAX         = 14346;
    localparam int DEF_GOOD_WINDOWS    = 2;
    localparam int DEF_RST_HOLD_CYCLES = 500;

endpackage

// File: rtl/tvp_clk_lock_sequencer_sync.sv
`timescale 1ns / 10ps
// Two-flop synchroniser with a rising-edge pulse taken from the synchronised stream.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/tvp_clk_lock_sequencer.sv
`timescale 1ns / 10ps
// Qualifies the PLL clock (lock + gated frequency count) before releasing the decoder reset.
module tvp_clk_lock_sequencer
    import tvp_clk_pkg::*;
#(
    parameter int GATE_CYCLES     = DEF_GATE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int CNT_MIN         = DEF_CNT_MIN,
    parameter int CNT_MAX         = DEF_CNT_MAX,
    parameter int GOOD_WINDOWS    = DEF_GOOD_WINDOWS,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             meas_clk,
    output logic             decoder_rst_n,
    output logic             clk_ready,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             freq_ok,
    output logic [7:0]       fault_count
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES);
    localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_WINDOWS - 1);
    localparam logic [CNT_W-1:0]  CNT_LO    = CNT_W'(CNT_MIN);
    localparam logic [CNT_W-1:0]  CNT_HI    = CNT_W'(CNT_MAX);

    logic w_locked_s;
    logic w_lock_rise_unused;
    logic w_meas_sync_unused;
    logic w_edge;

    sync_edge_detect u_lock_sync (
        .clk     (refclk),
        .rst     (rst),
        .i_async (pll_locked),
        .o_sync  (w_locked_s),
        .o_rise  (w_lock_rise_unused)
    );

    sync_edge_detect u_meas_sync (
        .clk     (refclk),
        .rst     (rst),
        .i_async (meas_clk),
        .o_sync  (w_meas_sync_unused),
        .o_rise  (w_edge)
    );

    lock_state_t       r_state;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_decoder_rst_n;
    logic              r_clk_ready;
    logic [CNT_W-1:0]  r_freq_count;
    logic              r_freq_valid;
    logic              r_freq_ok;
    logic [7:0]        r_fault_count;

    logic              w_gate_tc;
    logic [CNT_W-1:0]  w_win_count;
    logic              w_in_range;
    logic              w_fault;

    // Saturating count including the edge arriving in this cycle, so no edge straddles windows.
    assign w_gate_tc   = (r_gate_cnt == GATE_LAST);
    assign w_win_count = (r_edge_cnt == '1) ? r_edge_cnt : r_edge_cnt + CNT_W'(w_edge);
    assign w_in_range  = (w_win_count >= CNT_LO) && (w_win_count <= CNT_HI);
    assign w_fault     = w_gate_tc && !w_in_range;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state         <= WAIT_LOCK;
            r_gate_cnt      <= '0;
            r_edge_cnt      <= '0;
            r_good_cnt      <= '0;
            r_hold_cnt      <= '0;
            r_decoder_rst_n <= 1'b0;
            r_clk_ready     <= 1'b0;
            r_freq_count    <= '0;
            r_freq_valid    <= 1'b0;
            r_freq_ok       <= 1'b0;
            r_fault_count   <= 8'd0;
        end else begin
            r_freq_valid <= 1'b0;
            if (r_state == WAIT_LOCK) begin
                r_gate_cnt      <= '0;
                r_edge_cnt      <= '0;
                r_good_cnt      <= '0;
                r_decoder_rst_n <= 1'b0;
                r_clk_ready     <= 1'b0;
                if (w_locked_s) begin
                    r_state <= MEASURE;
                end
            end else if (!w_locked_s) begin
                // Lock loss overrides everything, including a window ending this cycle.
                r_state         <= WAIT_LOCK;
                r_gate_cnt      <= '0;
                r_edge_cnt      <= '0;
                r_decoder_rst_n <= 1'b0;
                r_clk_ready     <= 1'b0;
            end else begin
                if (w_gate_tc) begin
                    r_gate_cnt   <= '0;
                    r_edge_cnt   <= '0;
                    r_freq_count <= w_win_count;
                    r_freq_valid <= 1'b1;
                    r_freq_ok    <= w_in_range;
                end else begin
                    r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                    r_edge_cnt <= w_win_count;
                end

                case (r_state)
                    MEASURE: begin
                        if (w_gate_tc) begin
                            if (!w_in_range) begin
                                r_good_cnt <= '0;
                            end else if (r_good_cnt == GOOD_LAST) begin
                                r_state    <= HOLD_RST;
                                r_hold_cnt <= '0;
                                r_good_cnt <= '0;
                            end else begin
                                r_good_cnt <= r_good_cnt + GOOD_W'(1);
                            end
                        end
                    end
                    HOLD_RST: begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        if (w_fault) begin
                            r_state    <= MEASURE;
                            r_good_cnt <= '0;
                        end else if (r_hold_cnt == HOLD_LAST) begin
                            r_state         <= RUN;
                            r_decoder_rst_n <= 1'b1;
                            r_clk_ready     <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (w_fault) begin
                            r_state         <= MEASURE;
                            r_decoder_rst_n <= 1'b0;
                            r_clk_ready     <= 1'b0;
                            if (r_fault_count != 8'hFF) begin
                                r_fault_count <= r_fault_count + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign decoder_rst_n = r_decoder_rst_n;
    assign clk_ready     = r_clk_ready;
    assign freq_count    = r_freq_count;
    assign freq_valid    = r_freq_valid;
    assign freq_ok       = r_freq_ok;
    assign fault_count   = r_fault_count;

endmodule

// File: tb/tb_tvp_clk_lock_sequencer.sv
`timescale 1ns / 10ps
// Scoreboard bench: a window-level model predicts every frequency report and the sequencer outputs.
module tb_tvp_clk_lock_sequencer;

    localparam int GATE  = 500;
    localparam int CNT_W = 16;
    localparam int CMIN  = 141;
    localparam int CMAX  = 145;
    localparam int GOOD  = 2;
    localparam int HOLD  = 20;

    localparam int P_WAIT = 0;
    localparam int P_MEAS = 1;
    localparam int P_HOLD = 2;
    localparam int P_RUN  = 3;

    logic             refclk     = 1'b0;
    logic             rst        = 1'b1;
    logic             pll_locked = 1'b0;
    logic             meas_clk   = 1'b0;
    logic             decoder_rst_n;
    logic             clk_ready;
    logic [CNT_W-1:0] freq_count;
    logic             freq_valid;
    logic             freq_ok;
    logic [7:0]       fault_count;

    tvp_clk_lock_sequencer #(
        .GATE_CYCLES     (GATE),
        .CNT_W           (CNT_W),
        .CNT_MIN         (CMIN),
        .CNT_MAX         (CMAX),
        .GOOD_WINDOWS    (GOOD),
        .RST_HOLD_CYCLES (HOLD)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .meas_clk      (meas_clk),
        .decoder_rst_n (decoder_rst_n),
        .clk_ready     (clk_ready),
        .freq_count    (freq_count),
        .freq_valid    (freq_valid),
        .freq_ok       (freq_ok),
        .fault_count   (fault_count)
    );

    initial begin
        forever #10 refclk = ~refclk;
    end

    typedef struct {
        int count;
        bit ok;
    } win_t;

    win_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int n_win  = 0;
    bit slow   = 1'b0;

    // Reference model state: phase, window bookkeeping in absolute cycle numbers.
    int phase     = P_WAIT;
    int cyc       = 0;
    int win_start = 0;
    int win_edges = 0;
    int good      = 0;
    int run_due   = 0;
    int e_fault   = 0;
    int e_count   = 0;
    bit e_ok      = 1'b0;
    bit e_dec     = 1'b0;
    bit e_rdy     = 1'b0;
    bit md1 = 1'b0, md2 = 1'b0, md3 = 1'b0;
    bit ld1 = 1'b0, ld2 = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Input samples become visible to the sequencer two refclk edges after capture.
    task automatic model_step(input bit m_now, input bit l_now, input bit r_now);
        bit edge_seen;
        bit lock_seen;
        bit win_end;
        bit in_tol;
        edge_seen = md2 && !md3;
        lock_seen = ld2;
        win_end   = 1'b0;
        in_tol    = 1'b0;
        if (r_now) begin
            phase = P_WAIT; e_dec = 0; e_rdy = 0; e_fault = 0; e_count = 0; e_ok = 0;
            win_edges = 0; good = 0;
            md1 = 0; md2 = 0; md3 = 0; ld1 = 0; ld2 = 0;
        end else begin
            if (phase == P_WAIT) begin
                if (lock_seen) begin
                    phase = P_MEAS; win_start = cyc + 1; win_edges = 0; good = 0;
                end
            end else if (!lock_seen) begin
                phase = P_WAIT; e_dec = 0; e_rdy = 0;
            end else begin
                win_edges += int'(edge_seen);
                if ((cyc - win_start) % GATE == GATE - 1) begin
                    win_end = 1'b1;
                    e_count = (win_edges > 65535) ? 65535 : win_edges;
                    in_tol  = (e_count >= CMIN) && (e_count <= CMAX);
                    e_ok    = in_tol;
                    exp_q.push_back('{e_count, in_tol});
                    win_edges = 0;
                end
                if (phase == P_MEAS && win_end) begin
                    if (in_tol) begin
                        good++;
                        if (good == GOOD) begin
                            phase = P_HOLD; run_due = cyc + HOLD; good = 0;
                        end
                    end else begin
                        good = 0;
                    end
                end else if (phase == P_HOLD) begin
                    if (win_end && !in_tol) begin
                        phase = P_MEAS; good = 0;
                    end else if (cyc == run_due) begin
                        phase = P_RUN; e_dec = 1; e_rdy = 1;
                    end
                end else if (phase == P_RUN && win_end && !in_tol) begin
                    phase = P_MEAS; e_dec = 0; e_rdy = 0; good = 0;
                    if (e_fault < 255) e_fault++;
                end
            end
            md3 = md2; md2 = md1; md1 = m_now;
            ld2 = ld1; ld1 = l_now;
        end
        cyc++;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!freq_valid && n < budget);
        chk("freq_valid_within_budget", freq_valid, 1);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!clk_ready && n < budget);
        chk("clk_ready_within_budget", clk_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_decoder_rst_n"}, decoder_rst_n, 0);
        chk({tag, "_clk_ready"}, clk_ready, 0);
        chk({tag, "_freq_count"}, freq_count, 0);
        chk({tag, "_freq_ok"}, freq_ok, 0);
        chk({tag, "_fault_count"}, fault_count, 0);
    endtask

    initial begin
        int saw_valid;
        fork
            begin : meas_gen
                int unsigned ph;
                ph = $urandom_range(0, 499);
                // Keeps every meas_clk toggle off the refclk edges (odd 10 ps grid offset).
                #0.01;
                repeat (ph) #0.04;
                forever begin
                    if (slow) #40;
                    else #34.92;
                    meas_clk = ~meas_clk;
                end
            end
            begin : model
                forever begin
                    @(posedge refclk);
                    model_step(meas_clk, pll_locked, rst);
                end
            end
            begin : monitor
                win_t w;
                forever begin
                    @(negedge refclk);
                    chk("decoder_rst_n", decoder_rst_n, e_dec);
                    chk("clk_ready", clk_ready, e_rdy);
                    chk("fault_count", fault_count, e_fault);
                    chk("freq_count_level", freq_count, e_count);
                    chk("freq_ok_level", freq_ok, e_ok);
                    if (freq_valid || exp_q.size() > 0) begin
                        if (exp_q.size() == 0) begin
                            chk("freq_valid_unexpected", freq_valid, 0);
                        end else begin
                            w = exp_q.pop_front();
                            n_win++;
                            chk("freq_valid", freq_valid, 1);
                            chk("freq_count", freq_count, w.count);
                            chk("freq_ok", freq_ok, w.ok);
                            $display("window %0d: count=%0d ok=%0d (model %0d/%0d) rst_n=%0d ready=%0d faults=%0d",
                                     n_win, freq_count, freq_ok, w.count, w.ok,
                                     decoder_rst_n, clk_ready, fault_count);
                        end
                    end
                end
            end
        join_none

        // 1: reset then idle with no lock
        repeat (5) @(negedge refclk);
        check_reset_outputs("s1_reset");
        rst = 1'b0;
        repeat (1200 + $urandom_range(0, 100)) @(negedge refclk);
        check_reset_outputs("s1_nolock");

        // 2: lock with nominal clock, qualify into RUN
        pll_locked = 1'b1;
        wait_ready(3000);

        // 3: frequency fault in RUN, then re-qualify
        wait_valid(700);
        slow = 1'b1;
        wait_valid(700);
        chk("s3_freq_ok", freq_ok, 0);
        chk("s3_fault_count", fault_count, 1);
        slow = 1'b0;
        wait_ready(3000);

        // 4: alternating bad/good windows never qualify
        wait_valid(700);
        slow = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(700);
            chk("s4_decoder_rst_n", decoder_rst_n, 0);
            slow = (i % 2 == 1);
        end
        slow = 1'b0;
        chk("s4_fault_count", fault_count, 2);

        // 5a: lock drop landing exactly on a window end aborts that report
        wait_valid(700);
        repeat (497) @(negedge refclk);
        pll_locked = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge refclk);
            if (i == 10) pll_locked = 1'b1;
            if (freq_valid) saw_valid++;
        end
        chk("s5_aborted_window_valid", saw_valid, 0);

        // 5b: lock drop inside HOLD_RST
        wait_valid(700);
        wait_valid(700);
        pll_locked = 1'b0;
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (30) @(negedge refclk);
        chk("s5_hold_abort_ready", clk_ready, 0);
        chk("s5_hold_abort_rst_n", decoder_rst_n, 0);
        wait_ready(3000);

        // 6: reset in RUN, then full sequence again
        repeat ($urandom_range(50, 400)) @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        check_reset_outputs("s6_reset");
        rst = 1'b0;
        wait_ready(3000);

        repeat (20) @(negedge refclk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
